// File: rtl/strobe_fifo_pkg.sv
// strobe_fifo_pkg: shared definitions for the strobe receive FIFO.
// Holds the per-cycle operation encoding used by the occupancy update.
package strobe_fifo_pkg;

  // Encoded as {push, pop} so the decode can be built by concatenation.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/strobe_fifo_mem.sv
// strobe_fifo_mem: DEPTH x WIDTH storage for strobe_fifo.
// Ports:
//   clk   - write clock
//   we    - write enable, writes wdata at waddr on the rising edge
//   waddr - write address
//   wdata - write data
//   raddr - read address (asynchronous read)
//   rdata - word stored at raddr
// Contents are deliberately not reset.
module strobe_fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/strobe_fifo.sv
// strobe_fifo: receive-side buffer downstream of the strobe clock-domain
// crossing. Every strobe_in cycle queues data_in; words leave on a
// valid/ready interface. The crossing cannot be stalled, so a word arriving
// while full (and not popped in the same cycle) is dropped and a sticky
// overflow flag records the loss.
// Ports:
//   clk, reset    - destination clock, synchronous active-high reset
//   strobe_in     - one-cycle push pulse, data_in valid with it
//   data_in       - word to push
//   out_valid     - head word available (level != 0)
//   out_ready     - consumer accepts head word
//   out_data      - head word, meaningful only while out_valid
//   level         - occupancy 0..DEPTH
//   overflow      - sticky drop indicator
//   overflow_clr  - clears overflow (a same-cycle drop wins)
module strobe_fifo
  import strobe_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     strobe_in,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;

  logic     full;
  logic     pop;
  logic     push;
  logic     drop;
  fifo_op_e op;

  always_comb begin
    // Full/empty come from level alone; pointers are equal in both cases.
    full = (level_q == LVL_W'(DEPTH));
    pop  = (level_q != '0) && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push = strobe_in && (!full || pop);
    drop = strobe_in && full && !pop;
    op   = fifo_op_e'({push, pop});

    wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

    level_d = level_q;
    case (op)
      OP_PUSH: level_d = level_q + LVL_W'(1);
      OP_POP:  level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Drop takes priority over a simultaneous clear so no loss goes unseen.
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Reset gates the write so a word arriving with reset is not stored.
  strobe_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push && !reset),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

  assign out_valid = (level_q != '0);
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_strobe_fifo.sv
// tb_strobe_fifo: table-driven check of strobe_fifo (WIDTH=8, DEPTH=16).
// Each record gives the inputs held for one clock cycle and the outputs
// expected just after that cycle's rising edge.
module tb_strobe_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             strobe_in;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [4:0]       level;
  logic             overflow;
  logic             overflow_clr;

  strobe_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .strobe_in    (strobe_in),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       stb;
    logic [7:0] din;
    logic       rdy;
    logic       clr;
    logic       ev;   // expected out_valid
    logic [7:0] ed;   // expected out_data, checked only when ev
    logic [4:0] el;   // expected level
    logic       eo;   // expected overflow
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic void add(input logic rst, input logic stb, input logic [7:0] din,
                              input logic rdy, input logic clr, input logic ev,
                              input logic [7:0] ed, input logic [4:0] el, input logic eo);
    vec_t v;
    v.rst = rst; v.stb = stb; v.din = din; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
    vq.push_back(v);
  endfunction

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    reset        = v.rst;
    strobe_in    = v.stb;
    data_in      = v.din;
    out_ready    = v.rdy;
    overflow_clr = v.clr;
    @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== v.ev) begin
      n_fail++;
      $display("FAIL vec%0d out_valid: got %b want %b", idx, out_valid, v.ev);
    end
    if (level !== v.el) begin
      n_fail++;
      $display("FAIL vec%0d level: got %0d want %0d", idx, level, v.el);
    end
    if (overflow !== v.eo) begin
      n_fail++;
      $display("FAIL vec%0d overflow: got %b want %b", idx, overflow, v.eo);
    end
    if (v.ev && out_valid && (out_data !== v.ed)) begin
      n_fail++;
      $display("FAIL vec%0d out_data: got %02h want %02h", idx, out_data, v.ed);
    end
  endtask

  initial begin
    reset = 1'b1; strobe_in = 1'b0; data_in = '0; out_ready = 1'b0; overflow_clr = 1'b0;

    // Reset, then idle with out_ready held high.
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 5'd0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 8'h00, 1, 0, 0, 8'h00, 5'd0, 0);

    // Single push / pop.
    add(0, 1, 8'hA5, 0, 0, 1, 8'hA5, 5'd1, 0);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 5'd0, 0);

    // Two fill/drain passes; the second wraps the pointers.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++)
        add(0, 1, 8'(16*p + i), 0, 0, 1, 8'(16*p), 5'(i + 1), 0);
      for (int i = 0; i < 16; i++)
        add(0, 0, 8'h00, 1, 0, (i < 15), 8'(16*p + i + 1), 5'(15 - i), 0);
    end

    // Fill with 0x30..0x3F, then overflow and clear behaviour.
    for (int i = 0; i < 16; i++) add(0, 1, 8'(8'h30 + i), 0, 0, 1, 8'h30, 5'(i + 1), 0);
    add(0, 1, 8'hEE, 0, 0, 1, 8'h30, 5'd16, 1);  // dropped
    add(0, 0, 8'h00, 0, 1, 1, 8'h30, 5'd16, 0);  // clear
    add(0, 1, 8'hEE, 0, 1, 1, 8'h30, 5'd16, 1);  // drop beats clear
    add(0, 0, 8'h00, 0, 1, 1, 8'h30, 5'd16, 0);

    // Full with simultaneous push 0x77 and pop: no drop, 0x77 drains last.
    add(0, 1, 8'h77, 1, 0, 1, 8'h31, 5'd16, 0);
    for (int i = 0; i < 16; i++)
      add(0, 0, 8'h00, 1, 0, (i < 15), (i < 14) ? 8'(8'h32 + i) : 8'h77, 5'(15 - i), 0);

    // Reset with level 9 and a same-cycle push, then a fresh push.
    for (int i = 0; i < 9; i++) add(0, 1, 8'(8'h50 + i), 0, 0, 1, 8'h50, 5'(i + 1), 0);
    add(1, 1, 8'h99, 1, 0, 0, 8'h00, 5'd0, 0);
    add(0, 1, 8'h60, 0, 0, 1, 8'h60, 5'd1, 0);

    for (int i = 0; i < vq.size(); i++) step(vq[i], i);

    // After reset the first push lands in slot 0, so pointers are 1 and 0.
    n_vec++;
    if (dut.wr_ptr_q !== 4'd1 || dut.rd_ptr_q !== 4'd0) begin
      n_fail++;
      $display("FAIL ptr_after_reset: got wr=%0d rd=%0d want wr=1 rd=0",
               dut.wr_ptr_q, dut.rd_ptr_q);
    end
    if (dut.u_mem.mem_q[0] !== 8'h60) begin
      n_fail++;
      $display("FAIL slot0_after_reset: got %02h want 60", dut.u_mem.mem_q[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/strobe_fifo.md
# strobe_fifo

Receive-side buffer that sits directly downstream of the strobe clock-domain crossing, in the destination clock domain. It takes each single-cycle `strobe_in` pulse with its accompanying `data_in` word and queues it. Words are presented to the consumer (USB endpoint / DFU state logic) on a valid/ready interface. The crossing has no backpressure, so this block absorbs bursts, counts occupancy, drops words when full, and flags the loss with a sticky overflow bit.

## Interface
- `WIDTH`, 8, data word width in bits (matches the crossing's WIDTH).
- `DEPTH`, 16, number of storage entries; power of two, ≥ 2.
- `clk` input 1: destination-domain clock; everything is sampled on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `strobe_in` input 1: one-cycle push pulse from the crossing; each high cycle is one word.
- `data_in` input WIDTH: word to push; valid in the same cycle as `strobe_in`.
- `out_valid` output 1: head word available.
- `out_ready` input 1: consumer accepts head word.
- `out_data` output WIDTH: head word; meaningful only while `out_valid` is high.
- `level` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` output 1: sticky; set when a word was dropped.
- `overflow_clr` input 1: clears `overflow`.

## Operation
- Push: `strobe_in` high and (`level` < DEPTH, or a pop occurs in the same cycle) writes `data_in` at `wr_ptr`. `wr_ptr` increments modulo DEPTH.
- Pop: `out_valid && out_ready` consumes the head. `rd_ptr` increments modulo DEPTH.
- `out_valid` = (`level` != 0). `out_data` = mem[`rd_ptr`], read combinationally from registered storage.
- Level update: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Full with simultaneous push and pop: both are accepted and `level` stays DEPTH. No drop and no overflow.
- Empty with push: no bypass. The word appears the next cycle. `out_ready` while empty has no effect.
- Drop: `strobe_in` high, `level` == DEPTH, and no pop in that cycle. The word is discarded, the pointers and `level` are unchanged, and `overflow` is set on the next edge.
- `overflow_clr` clears `overflow`. If a drop happens in the same cycle as the clear, set wins.
- Pointers are ADDR_W = $clog2(DEPTH) bits and wrap naturally. Full/empty are determined from `level` only, never from pointer comparison.
- `out_ready` asserted while `out_valid` is low is ignored.

## Timing
- Reset values: `out_valid`=0, `level`=0, `overflow`=0, `wr_ptr`=`rd_ptr`=0. `out_data` is don't-care; the bench must not check it while `out_valid`=0. Storage contents are not reset.
- Reset mid-operation: the queue empties on the next edge and queued words are lost. `reset` overrides any push, pop or clear in the same cycle.
- Latency: `strobe_in` at edge N → `out_valid`=1 and `out_data`=word after edge N, i.e. visible in cycle N+1.
- Pop at edge N → next word (if any) on `out_data` in cycle N+1.
- Sustained throughput: one push and one pop per cycle.
- Back-to-back strobes: a push is legal every cycle. Each high cycle is a distinct word; the block does no edge detection.

## Structure
- No shared-package types are needed. ADDR_W is a localparam derived from DEPTH.
- One sub-module is natural: `strobe_fifo_mem` — DEPTH×WIDTH, one synchronous write port, one asynchronous read port, no reset.
- `strobe_fifo` holds the pointers, `level`, the push/pop/drop decode and the overflow register.
- Instantiated with the crossing's `strobe_out`/`data_out` wired to `strobe_in`/`data_in`.

## Test plan
- Reset then idle. Response: `out_valid`=0, `level`=0, `overflow`=0. With `out_ready`=1 held for 10 cycles, `level` stays 0.
- Single push of 0xA5 at edge N. Response: `out_valid`=1 and `out_data`=0xA5 in cycle N+1, `level`=1. A pop then returns `level`=0 and `out_valid`=0.
- 16 consecutive strobes (0x00..0x0F) with `out_ready`=0, then drain. Response: `level`=16, then words are read in order 0x00..0x0F, with a wrap check on a second pass of 0x10..0x1F.
- Full FIFO plus a 17th strobe (0xEE) with no pop. Response: 0xEE is dropped, `level`=16, `overflow`=1. `overflow_clr` → 0. Clear and drop in the same cycle → `overflow` stays 1.
- Full FIFO with push 0x77 and pop in the same cycle. Response: `level`=16, `overflow`=0, and 0x77 is the last word drained.
- Reset asserted with `level`=9 and a push in the same cycle. Response: next cycle `level`=0, `out_valid`=0, and later pushes start at `wr_ptr`=0.
